inverse_matrix: RTL and testbench

// Self-contained 2x2 signed matrix inverter. A matrix held in an internal register file is inverted

---
 rtl/inverse_matrix.sv | 174 +++++++++++++++++
 tb/tb_inverse_matrix.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/inverse_matrix.sv
// 2x2 signed matrix inverter: adjugate elements divided by the determinant with a
// sequential restoring divider, streamed out as Q16.16 with write strobe and status.
module inverse_matrix #(
  parameter logic signed [15:0] A00_INIT = 16'sd4,
  parameter logic signed [15:0] A01_INIT = 16'sd7,
  parameter logic signed [15:0] A10_INIT = 16'sd2,
  parameter logic signed [15:0] A11_INIT = 16'sd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] ran_acc_mem,
  output logic [31:0] wr_st
);

  typedef enum logic [2:0] {StIdle, StDet, StDiv, StWr, StDone} state_e;

  state_e r_state, w_state_d;

  logic               r_start_d;
  logic signed [15:0] r_a00, r_a01, r_a10, r_a11;
  logic [31:0]        r_dvs;
  logic               r_det_neg;
  logic               r_num_neg;
  logic [31:0]        r_rem;
  logic [31:0]        r_quo;
  logic [4:0]         r_cnt;
  logic [1:0]         r_k;
  logic               r_done, r_busy, r_sing, r_wr;
  logic [1:0]         r_idx;
  logic [31:0]        r_res;

  logic               w_launch;
  logic signed [32:0] w_det;
  logic [31:0]        w_det_mag;
  logic [1:0]         w_load_k;
  logic signed [16:0] w_adj;
  logic [15:0]        w_adj_mag;
  logic [31:0]        w_num_mag;
  logic [32:0]        w_trial;
  logic               w_ge;
  logic [31:0]        w_rem_nx;
  logic [31:0]        w_qmag;
  logic [31:0]        w_q;

  assign w_launch = start & ~r_start_d & ((r_state == StIdle) | (r_state == StDone));

  assign w_det     = 33'(r_a00) * 33'(r_a11) - 33'(r_a01) * 33'(r_a10);
  assign w_det_mag = w_det[32] ? 32'(-w_det) : 32'(w_det);

  // Element loaded into the divider: first from DET, the following ones from WR.
  assign w_load_k = (r_state == StWr) ? r_k + 2'd1 : 2'd0;

  // Adjugate is 17-bit so that -(-32768) stays positive.
  always_comb begin
    w_adj = '0;
    unique case (w_load_k)
      2'd0: w_adj = 17'(r_a11);
      2'd1: w_adj = -17'(r_a01);
      2'd2: w_adj = -17'(r_a10);
      2'd3: w_adj = 17'(r_a00);
      default: w_adj = '0;
    endcase
  end

  assign w_adj_mag = w_adj[16] ? 16'(-w_adj) : 16'(w_adj);
  assign w_num_mag = {w_adj_mag, 16'h0000};

  assign w_trial  = {r_rem, r_quo[31]};
  assign w_ge     = w_trial >= {1'b0, r_dvs};
  assign w_rem_nx = w_ge ? 32'(w_trial - {1'b0, r_dvs}) : w_trial[31:0];
  assign w_qmag   = {r_quo[30:0], w_ge};

  always_comb begin
    if (r_num_neg ^ r_det_neg) begin
      w_q = -w_qmag;
    end else if (w_qmag[31]) begin
      w_q = 32'h7FFF_FFFF;
    end else begin
      w_q = w_qmag;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_launch) w_state_d = StDet;
      StDet:   w_state_d = (w_det == '0) ? StDone : StDiv;
      StDiv:   if (r_cnt == 5'd31) w_state_d = StWr;
      StWr:    w_state_d = (r_k == 2'd3) ? StDone : StDiv;
      StDone:  if (w_launch) w_state_d = StDet;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_d <= 1'b0;
      r_a00     <= A00_INIT;
      r_a01     <= A01_INIT;
      r_a10     <= A10_INIT;
      r_a11     <= A11_INIT;
      r_dvs     <= '0;
      r_det_neg <= 1'b0;
      r_num_neg <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_k       <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_sing    <= 1'b0;
      r_wr      <= 1'b0;
      r_idx     <= '0;
      r_res     <= '0;
    end else begin
      r_start_d <= start;
      // Status bits track the state being entered so they line up with it.
      r_busy <= (w_state_d == StDet) | (w_state_d == StDiv) | (w_state_d == StWr);
      r_done <= (w_state_d == StDone);
      r_wr   <= (w_state_d == StWr);
      if (w_launch) begin
        r_sing <= 1'b0;
        r_idx  <= '0;
      end
      unique case (r_state)
        StDet: begin
          r_dvs     <= w_det_mag;
          r_det_neg <= w_det[32];
          r_rem     <= '0;
          r_quo     <= w_num_mag;
          r_num_neg <= w_adj[16];
          r_cnt     <= '0;
          r_k       <= '0;
          if (w_det == '0) begin
            r_sing <= 1'b1;
            r_res  <= '0;
          end
        end
        StDiv: begin
          r_rem <= w_rem_nx;
          r_quo <= w_qmag;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_res <= w_q;
            r_idx <= r_k;
          end
        end
        StWr: begin
          if (r_k != 2'd3) begin
            r_k       <= w_load_k;
            r_rem     <= '0;
            r_quo     <= w_num_mag;
            r_num_neg <= w_adj[16];
            r_cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ran_acc_mem = r_res;
  assign wr_st       = {r_done, r_busy, r_sing, 20'b0, r_wr, 6'b0, r_idx};

endmodule

// File: tb/tb_inverse_matrix.sv
// Directed bench: four inverter instances with different reset matrices share clock,
// reset and start; results are compared against hand-computed Q16.16 values.
module tb_inverse_matrix;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] def_res, def_st, sing_res, sing_st, neg_res, neg_st, id_res, id_st;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inverse_matrix u_def (
    .clk(clk), .rst_n(rst_n), .start(start), .ran_acc_mem(def_res), .wr_st(def_st)
  );

  inverse_matrix #(
    .A00_INIT(16'sd1), .A01_INIT(16'sd2), .A10_INIT(16'sd2), .A11_INIT(16'sd4)
  ) u_sing (
    .clk(clk), .rst_n(rst_n), .start(start), .ran_acc_mem(sing_res), .wr_st(sing_st)
  );

  inverse_matrix #(
    .A00_INIT(16'sd0), .A01_INIT(16'sh8000), .A10_INIT(16'sd1), .A11_INIT(16'sd0)
  ) u_neg (
    .clk(clk), .rst_n(rst_n), .start(start), .ran_acc_mem(neg_res), .wr_st(neg_st)
  );

  inverse_matrix #(
    .A00_INIT(16'sd1), .A01_INIT(16'sd0), .A10_INIT(16'sd0), .A11_INIT(-16'sd1)
  ) u_id (
    .clk(clk), .rst_n(rst_n), .start(start), .ran_acc_mem(id_res), .wr_st(id_st)
  );

  logic [31:0] exp_def [4] = '{32'h0000_9999, 32'hFFFF_4CCD, 32'hFFFF_CCCD, 32'h0000_6666};
  logic [31:0] exp_neg [4] = '{32'h0000_0000, 32'h0001_0000, 32'hFFFF_FFFE, 32'h0000_0000};
  logic [31:0] exp_id  [4] = '{32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One start edge, then 180 observed cycles; cycle c is sampled after edge E0+c.
  task automatic run_and_check(input string name, input bit hold_start, input bit mid_edge);
    logic [31:0] got_def [4];
    logic [31:0] got_idx [4];
    logic [31:0] got_neg [4];
    logic [31:0] got_id  [4];
    int          wr_cyc  [4];
    int n_def = 0, n_neg = 0, n_id = 0, n_sing = 0;
    for (int i = 0; i < 4; i++) begin
      got_def[i] = 'x; got_idx[i] = 'x; got_neg[i] = 'x; got_id[i] = 'x; wr_cyc[i] = -1;
    end
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 180; c++) begin
      @(negedge clk);
      if (c == 0 && !hold_start) start = 1'b0;
      if (mid_edge && c == 50) start = 1'b0;
      if (mid_edge && c == 52) start = 1'b1;
      if (c == 2) begin
        check_eq({name, "_sing_st"}, sing_st, 32'hA000_0000);
        check_eq({name, "_sing_res"}, sing_res, 32'h0);
      end
      if (def_st[8]) begin
        if (n_def < 4) begin
          got_def[n_def] = def_res;
          got_idx[n_def] = {30'b0, def_st[1:0]};
          wr_cyc[n_def]  = c;
        end
        n_def++;
      end
      if (neg_st[8]) begin
        if (n_neg < 4) got_neg[n_neg] = neg_res;
        n_neg++;
      end
      if (id_st[8]) begin
        if (n_id < 4) got_id[n_id] = id_res;
        n_id++;
      end
      if (sing_st[8]) n_sing++;
    end
    start = 1'b0;
    check_eq({name, "_n_wr"}, n_def, 4);
    check_eq({name, "_n_sing_wr"}, n_sing, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_cyc%0d", name, i), wr_cyc[i], 33 + 33 * i);
      check_eq($sformatf("%s_def%0d", name, i), got_def[i], exp_def[i]);
      check_eq($sformatf("%s_idx%0d", name, i), got_idx[i], i);
      check_eq($sformatf("%s_neg%0d", name, i), got_neg[i], exp_neg[i]);
      check_eq($sformatf("%s_id%0d", name, i), got_id[i], exp_id[i]);
    end
    check_eq({name, "_def_final_st"}, def_st, 32'h8000_0003);
    check_eq({name, "_def_final_res"}, def_res, exp_def[3]);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_res", def_res, 32'h0);
    check_eq("rst_st", def_st, 32'h0);
    rst_n = 1'b1;

    bad = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if ((def_res | def_st | sing_res | sing_st | neg_res | neg_st | id_res | id_st) != 0) bad++;
    end
    check_eq("idle_quiet", bad, 0);

    run_and_check("pulse", 1'b0, 1'b0);
    run_and_check("hold", 1'b1, 1'b0);
    run_and_check("busy_edge", 1'b0, 1'b1);

    // Abort in the middle of the second element's divide.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("pre_abort_busy", {31'b0, def_st[30]}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_res", def_res, 32'h0);
    check_eq("abort_st", def_st, 32'h0);
    check_eq("abort_neg_res", neg_res, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_and_check("after_abort", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
